// File: rtl/pipe_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
// Shared definitions for the pipeline control unit of the 5-stage core:
//   - CTRL_RUN / CTRL_DRAIN state encoding of the serialization FSM
//   - register index width used by the hazard compare
//   - packed bundle of the per-stage stall/bubble controls and the fixed
//     patterns each hazard rule drives onto it
//   - NOP word the stage registers load when their bubble input is high
// ---------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

    localparam int unsigned REG_IDX_W   = 5;
    localparam int unsigned DRAIN_CNT_W = 4;   // holds DRAIN_CYCLES-1 for DRAIN_CYCLES <= 15
    localparam int unsigned WAIT_CNT_W  = 16;  // holds MEM_TIMEOUT <= 65535

    // Stage registers insert this word (addi x0, x0, 0) when bubbled.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        CTRL_RUN   = 1'b0,
        CTRL_DRAIN = 1'b1
    } ctrl_state_e;

    typedef struct packed {
        logic regF_stall;
        logic regD_stall;
        logic regD_bubble;
        logic regE_stall;
        logic regE_bubble;
        logic regM_stall;
        logic regW_bubble;
    } ctrl_out_t;

    localparam ctrl_out_t CTRL_OUT_NONE     = ctrl_out_t'(7'b000_0000);
    // Reset: flush every register that has a bubble input, hold nothing.
    localparam ctrl_out_t CTRL_OUT_RESET    = ctrl_out_t'(7'b001_0101);
    // Memory wait: freeze F..M, let W drain a NOP.
    localparam ctrl_out_t CTRL_OUT_MEMWAIT  = ctrl_out_t'(7'b110_1011);
    // Redirect: squash the two wrong-path instructions in D and E.
    localparam ctrl_out_t CTRL_OUT_REDIRECT = ctrl_out_t'(7'b001_0100);
    // Load-use and drain: hold F/D, inject a NOP into E.
    localparam ctrl_out_t CTRL_OUT_HOLD_D   = ctrl_out_t'(7'b110_0100);

endpackage

// File: rtl/pipe_hazard_detect.sv
// ---------------------------------------------------------------------------
// pipe_hazard_detect
// Combinational load-use compare between the load in E and the sources of
// the instruction in D. x0 never creates a hazard.
// Ports:
//   i_load      E instruction is a load
//   i_rd        E destination register
//   i_rs1/rs2   D source registers
//   i_rs1_used  D instruction reads rs1 (i_rs2_used likewise)
//   o_hazard    D must wait one cycle for the load data
// ---------------------------------------------------------------------------
module pipe_hazard_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic                 i_load,
    input  logic [REG_IDX_W-1:0] i_rd,
    input  logic [REG_IDX_W-1:0] i_rs1,
    input  logic [REG_IDX_W-1:0] i_rs2,
    input  logic                 i_rs1_used,
    input  logic                 i_rs2_used,
    output logic                 o_hazard
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit = i_rs1_used & (i_rs1 == i_rd);
    assign w_rs2_hit = i_rs2_used & (i_rs2 == i_rd);
    assign o_hazard  = i_load & (i_rd != '0) & (w_rs1_hit | w_rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Pipeline control unit of the 5-stage core. Produces the stall/bubble
// controls for regF..regW from four prioritized hazard rules (memory wait,
// redirect, load-use, serialization drain), runs the drain FSM, a memory
// wait watchdog and a free-running stall-cycle counter.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   decode_i_*               D-stage sources, source-used flags, serial flag
//   regE_i_load/wb_rd        load in E and its destination
//   execute_i_redirect       E-stage mispredict redirect
//   regM_i_mem_req           M accesses data memory this cycle
//   mem_i_ready              data memory completes the M access
//   ctrl_o_reg*_stall/bubble per-stage controls (combinational)
//   ctrl_o_mem_timeout       sticky watchdog flag
//   ctrl_o_stall_cnt         number of cycles with regF stalled (wraps)
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned MEM_TIMEOUT  = 255,
    parameter int unsigned CNT_W        = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] decode_i_rs1,
    input  logic [REG_IDX_W-1:0] decode_i_rs2,
    input  logic                 decode_i_rs1_used,
    input  logic                 decode_i_rs2_used,
    input  logic                 decode_i_serial,
    input  logic                 regE_i_load,
    input  logic [REG_IDX_W-1:0] regE_i_wb_rd,
    input  logic                 execute_i_redirect,
    input  logic                 regM_i_mem_req,
    input  logic                 mem_i_ready,
    output logic                 ctrl_o_regF_stall,
    output logic                 ctrl_o_regD_stall,
    output logic                 ctrl_o_regD_bubble,
    output logic                 ctrl_o_regE_stall,
    output logic                 ctrl_o_regE_bubble,
    output logic                 ctrl_o_regM_stall,
    output logic                 ctrl_o_regW_bubble,
    output logic                 ctrl_o_mem_timeout,
    output logic [CNT_W-1:0]     ctrl_o_stall_cnt
);

    localparam logic [DRAIN_CNT_W-1:0] DRAIN_INIT = DRAIN_CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [WAIT_CNT_W-1:0]  WAIT_LIMIT = WAIT_CNT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_CNT_W-1:0]  WAIT_MAX   = '1;
    localparam logic [CNT_W-1:0]       CNT_ONE    = CNT_W'(1);

    ctrl_state_e            r_state;
    ctrl_state_e            w_state_nxt;
    logic [DRAIN_CNT_W-1:0] r_drain_cnt;
    logic [DRAIN_CNT_W-1:0] w_drain_cnt_nxt;
    logic                   r_serial_done;
    logic                   w_serial_done_nxt;
    logic [WAIT_CNT_W-1:0]  r_wait_cnt;
    logic [WAIT_CNT_W-1:0]  w_wait_cnt_nxt;
    logic                   r_mem_timeout;
    logic [CNT_W-1:0]       r_stall_cnt;

    logic      w_memwait;
    logic      w_redirect;
    logic      w_loaduse;
    logic      w_drain;
    logic      w_drain_entry;
    ctrl_out_t w_out;

    pipe_hazard_detect u_detect (
        .i_load     (regE_i_load),
        .i_rd       (regE_i_wb_rd),
        .i_rs1      (decode_i_rs1),
        .i_rs2      (decode_i_rs2),
        .i_rs1_used (decode_i_rs1_used),
        .i_rs2_used (decode_i_rs2_used),
        .o_hazard   (w_loaduse)
    );

    assign w_memwait  = regM_i_mem_req & ~mem_i_ready;
    assign w_redirect = execute_i_redirect;
    assign w_drain    = (r_state == CTRL_DRAIN) |
                        ((r_state == CTRL_RUN) & decode_i_serial & ~r_serial_done);
    // Drain only starts in a cycle where the drain rule actually owns the outputs.
    assign w_drain_entry = (r_state == CTRL_RUN) & decode_i_serial & ~r_serial_done &
                           ~w_loaduse;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= CTRL_RUN;
            r_drain_cnt   <= '0;
            r_serial_done <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_drain_cnt   <= w_drain_cnt_nxt;
            r_serial_done <= w_serial_done_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic. Memory wait freezes everything; redirect aborts a
    // drain. r_drain_cnt is the number of DRAIN cycles still to come, so a
    // serial instruction sees exactly DRAIN_CYCLES stall cycles.
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt       = r_state;
        w_drain_cnt_nxt   = r_drain_cnt;
        w_serial_done_nxt = r_serial_done;
        if (!w_memwait) begin
            if (w_redirect) begin
                w_state_nxt       = CTRL_RUN;
                w_drain_cnt_nxt   = '0;
                w_serial_done_nxt = 1'b0;
            end else if (r_state == CTRL_RUN) begin
                if (w_drain_entry) begin
                    if (DRAIN_CYCLES == 1) begin
                        w_serial_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt     = CTRL_DRAIN;
                        w_drain_cnt_nxt = DRAIN_INIT;
                    end
                end else if (!w_out.regD_stall) begin
                    // The serial instruction left D this cycle.
                    w_serial_done_nxt = 1'b0;
                end
            end else begin
                if (r_drain_cnt <= DRAIN_CNT_W'(1)) begin
                    w_state_nxt       = CTRL_RUN;
                    w_drain_cnt_nxt   = '0;
                    w_serial_done_nxt = 1'b1;
                end else begin
                    w_drain_cnt_nxt = r_drain_cnt - DRAIN_CNT_W'(1);
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Output logic: exactly one rule drives the controls, highest first.
    // -----------------------------------------------------------------------
    always_comb begin
        w_out = CTRL_OUT_NONE;
        if (!rst) begin
            w_out = CTRL_OUT_RESET;
        end else if (w_memwait) begin
            w_out = CTRL_OUT_MEMWAIT;
        end else if (w_redirect) begin
            w_out = CTRL_OUT_REDIRECT;
        end else if (w_loaduse || w_drain) begin
            w_out = CTRL_OUT_HOLD_D;
        end
    end

    assign ctrl_o_regF_stall  = w_out.regF_stall;
    assign ctrl_o_regD_stall  = w_out.regD_stall;
    assign ctrl_o_regD_bubble = w_out.regD_bubble;
    assign ctrl_o_regE_stall  = w_out.regE_stall;
    assign ctrl_o_regE_bubble = w_out.regE_bubble;
    assign ctrl_o_regM_stall  = w_out.regM_stall;
    assign ctrl_o_regW_bubble = w_out.regW_bubble;

    // -----------------------------------------------------------------------
    // Watchdog and stall counter
    // -----------------------------------------------------------------------
    always_comb begin
        w_wait_cnt_nxt = '0;
        if (w_memwait) begin
            w_wait_cnt_nxt = (r_wait_cnt == WAIT_MAX) ? r_wait_cnt
                                                      : r_wait_cnt + WAIT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
            r_stall_cnt   <= '0;
        end else begin
            r_wait_cnt <= w_wait_cnt_nxt;
            if (w_memwait && (w_wait_cnt_nxt >= WAIT_LIMIT)) begin
                r_mem_timeout <= 1'b1;
            end
            if (w_out.regF_stall) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
        end
    end

    assign ctrl_o_mem_timeout = r_mem_timeout;
    assign ctrl_o_stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed bench for pipe_hazard_ctrl (DRAIN_CYCLES=3, MEM_TIMEOUT=4).
// Inputs change 1 time unit after the rising edge; combinational outputs
// are sampled 1 unit later, registered outputs after the following edge.
// Control outputs are compared as {F_stall, D_stall, D_bubble, E_stall,
// E_bubble, M_stall, W_bubble}.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam logic [6:0] O_NONE  = 7'b000_0000;
    localparam logic [6:0] O_RST   = 7'b001_0101;
    localparam logic [6:0] O_MW    = 7'b110_1011;
    localparam logic [6:0] O_RD    = 7'b001_0100;
    localparam logic [6:0] O_STALL = 7'b110_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1, rs2, wb_rd;
    logic        rs1_used, rs2_used, serial, load, redirect, mem_req, mem_ready;
    logic        f_st, d_st, d_bb, e_st, e_bb, m_st, w_bb, timeout;
    logic [31:0] stall_cnt;
    logic [6:0]  obs;

    int checks = 0;
    int errors = 0;

    assign obs = {f_st, d_st, d_bb, e_st, e_bb, m_st, w_bb};

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .DRAIN_CYCLES (3),
        .MEM_TIMEOUT  (4),
        .CNT_W        (32)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .decode_i_rs1       (rs1),
        .decode_i_rs2       (rs2),
        .decode_i_rs1_used  (rs1_used),
        .decode_i_rs2_used  (rs2_used),
        .decode_i_serial    (serial),
        .regE_i_load        (load),
        .regE_i_wb_rd       (wb_rd),
        .execute_i_redirect (redirect),
        .regM_i_mem_req     (mem_req),
        .mem_i_ready        (mem_ready),
        .ctrl_o_regF_stall  (f_st),
        .ctrl_o_regD_stall  (d_st),
        .ctrl_o_regD_bubble (d_bb),
        .ctrl_o_regE_stall  (e_st),
        .ctrl_o_regE_bubble (e_bb),
        .ctrl_o_regM_stall  (m_st),
        .ctrl_o_regW_bubble (w_bb),
        .ctrl_o_mem_timeout (timeout),
        .ctrl_o_stall_cnt   (stall_cnt)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rs1 = 5'd0; rs2 = 5'd0; wb_rd = 5'd0;
        rs1_used = 1'b0; rs2_used = 1'b0; serial = 1'b0; load = 1'b0;
        redirect = 1'b0; mem_req = 1'b0; mem_ready = 1'b1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        next_cycle();
        rst = 1'b1;
        next_cycle();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (obs !== O_NONE) begin errors++;
            $display("FAIL reset_idle_out: got %b expected %b", obs, O_NONE); end
        checks++; if (stall_cnt !== 32'd0) begin errors++;
            $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
        checks++; if (timeout !== 1'b0) begin errors++;
            $display("FAIL reset_timeout: got %b expected 0", timeout); end
        // Enter a drain, then reset in its third stall cycle (DRAIN, cnt=1).
        serial = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (obs !== O_STALL) begin errors++;
                $display("FAIL reset_pre_drain%0d: got %b expected %b", i, obs, O_STALL); end
            if (i < 2) next_cycle();
        end
        rst = 1'b0;
        #1;
        checks++; if (obs !== O_RST) begin errors++;
            $display("FAIL reset_forced_out: got %b expected %b", obs, O_RST); end
        checks++; if (stall_cnt !== 32'd0) begin errors++;
            $display("FAIL reset_async_cnt: got %0d expected 0", stall_cnt); end
        next_cycle();
        rst = 1'b1;
        // Back in RUN with the drain counter cleared: a full 3-cycle drain again.
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (obs !== O_STALL) begin errors++;
                $display("FAIL reset_post_drain%0d: got %b expected %b", i, obs, O_STALL); end
            next_cycle();
        end
        checks++; if (obs !== O_NONE) begin errors++;
            $display("FAIL reset_post_release: got %b expected %b", obs, O_NONE); end
        checks++; if (stall_cnt !== 32'd3) begin errors++;
            $display("FAIL reset_post_cnt: got %0d expected 3", stall_cnt); end
        serial = 1'b0;
    endtask

    task automatic test_loaduse();
        do_reset();
        load = 1'b1; wb_rd = 5'd5; rs1 = 5'd1; rs1_used = 1'b1; rs2 = 5'd5; rs2_used = 1'b1;
        #1;
        checks++; if (obs !== O_STALL) begin errors++;
            $display("FAIL loaduse_rs2: got %b expected %b", obs, O_STALL); end
        next_cycle();
        load = 1'b0;  // E now holds the inserted bubble
        #1;
        checks++; if (obs !== O_NONE) begin errors++;
            $display("FAIL loaduse_release: got %b expected %b", obs, O_NONE); end
        checks++; if (stall_cnt !== 32'd1) begin errors++;
            $display("FAIL loaduse_cnt: got %0d expected 1", stall_cnt); end
        load = 1'b1; wb_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
        #1;
        checks++; if (obs !== O_NONE) begin errors++;
            $display("FAIL loaduse_x0: got %b expected %b", obs, O_NONE); end
        wb_rd = 5'd7; rs1 = 5'd7; rs1_used = 1'b0; rs2 = 5'd3;
        #1;
        checks++; if (obs !== O_NONE) begin errors++;
            $display("FAIL loaduse_rs1_unused: got %b expected %b", obs, O_NONE); end
        rs1_used = 1'b1;
        #1;
        checks++; if (obs !== O_STALL) begin errors++;
            $display("FAIL loaduse_rs1: got %b expected %b", obs, O_STALL); end
        redirect = 1'b1;
        #1;
        checks++; if (obs !== O_RD) begin errors++;
            $display("FAIL loaduse_vs_redirect: got %b expected %b", obs, O_RD); end
        clear_inputs();
    endtask

    task automatic test_serial_drain();
        do_reset();
        serial = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (obs !== O_STALL) begin errors++;
                $display("FAIL drain_cycle%0d: got %b expected %b", i, obs, O_STALL); end
            next_cycle();
        end
        checks++; if (obs !== O_NONE) begin errors++;
            $display("FAIL drain_advance: got %b expected %b", obs, O_NONE); end
        checks++; if (stall_cnt !== 32'd3) begin errors++;
            $display("FAIL drain_cnt: got %0d expected 3", stall_cnt); end
        next_cycle();
        serial = 1'b0;
        #1;
        checks++; if (obs !== O_NONE) begin errors++;
            $display("FAIL drain_no_redrain: got %b expected %b", obs, O_NONE); end
    endtask

    task automatic test_redirect();
        do_reset();
        serial = 1'b1;
        next_cycle();   // RUN entry cycle done
        next_cycle();   // first DRAIN cycle done
        redirect = 1'b1;
        #1;
        checks++; if (obs !== O_RD) begin errors++;
            $display("FAIL redirect_in_drain: got %b expected %b", obs, O_RD); end
        next_cycle();
        redirect = 1'b0;
        // serial_done was cleared, so a serial instr in D drains in full.
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (obs !== O_STALL) begin errors++;
                $display("FAIL redirect_redrain%0d: got %b expected %b", i, obs, O_STALL); end
            next_cycle();
        end
        checks++; if (obs !== O_NONE) begin errors++;
            $display("FAIL redirect_redrain_end: got %b expected %b", obs, O_NONE); end

        // Memory wait masks a redirect and freezes the drain.
        do_reset();
        serial = 1'b1;
        next_cycle();
        mem_req = 1'b1; mem_ready = 1'b0; redirect = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (obs !== O_MW) begin errors++;
                $display("FAIL memwait_over_redirect%0d: got %b expected %b", i, obs, O_MW); end
            next_cycle();
        end
        mem_req = 1'b0; mem_ready = 1'b1; redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (obs !== O_STALL) begin errors++;
                $display("FAIL frozen_drain%0d: got %b expected %b", i, obs, O_STALL); end
            next_cycle();
        end
        checks++; if (obs !== O_NONE) begin errors++;
            $display("FAIL frozen_drain_end: got %b expected %b", obs, O_NONE); end
        checks++; if (stall_cnt !== 32'd5) begin errors++;
            $display("FAIL frozen_drain_cnt: got %0d expected 5", stall_cnt); end
        clear_inputs();
    endtask

    task automatic test_memwait();
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (obs !== O_MW) begin errors++;
                $display("FAIL memwait_cycle%0d: got %b expected %b", i, obs, O_MW); end
            checks++; if (timeout !== 1'b0) begin errors++;
                $display("FAIL memwait_timeout_early%0d: got %b expected 0", i, timeout); end
            next_cycle();
        end
        mem_ready = 1'b1;
        #1;
        checks++; if (obs !== O_NONE) begin errors++;
            $display("FAIL memwait_ready: got %b expected %b", obs, O_NONE); end
        checks++; if (stall_cnt !== 32'd4) begin errors++;
            $display("FAIL memwait_cnt: got %0d expected 4", stall_cnt); end
        checks++; if (timeout !== 1'b1) begin errors++;
            $display("FAIL memwait_timeout_set: got %b expected 1", timeout); end
        mem_req = 1'b0;
        next_cycle();
        next_cycle();
        checks++; if (timeout !== 1'b1) begin errors++;
            $display("FAIL memwait_timeout_sticky: got %b expected 1", timeout); end
        do_reset();
        checks++; if (timeout !== 1'b0) begin errors++;
            $display("FAIL memwait_timeout_reset: got %b expected 0", timeout); end
    endtask

    task automatic test_timeout_boundary();
        do_reset();
        // 3 waits, one ready cycle, 3 waits: the count restarts, no timeout.
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) next_cycle();
        mem_ready = 1'b1;
        next_cycle();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) next_cycle();
        checks++; if (timeout !== 1'b0) begin errors++;
            $display("FAIL timeout_restart: got %b expected 0", timeout); end
        next_cycle();
        checks++; if (timeout !== 1'b1) begin errors++;
            $display("FAIL timeout_fourth: got %b expected 1", timeout); end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst = 1'b0;
        test_reset();
        test_loaduse();
        test_serial_drain();
        test_redirect();
        test_memwait();
        test_timeout_boundary();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no end of test, expected finish before 100000");
        $fatal(1, "bench time limit expired");
    end

endmodule
